// File: rtl/corescore_uart_pkg.sv
// Shared types and timing helpers for the corescore UART receiver.
package corescore_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;

  // Rounded integer division so the bit period error stays below half a clock.
  function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
    return (clk_freq_hz + baud / 2) / baud;
  endfunction

  function automatic int bit_cnt_width(input int cpb);
    int w;
    w = $clog2(cpb);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/corescore_uart_rx_fifo.sv
// Circular receive FIFO; pointers carry one extra wrap bit to tell full from empty.
module corescore_uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_push,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_overrun
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        overrun_reg;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop   = !empty && i_ready;
  // A pop in the same cycle frees the slot being written, even when full.
  assign wr_en = i_push && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (i_push && !wr_en) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign o_valid   = !empty;
  assign o_data    = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];
  assign o_overrun = overrun_reg;

endmodule

// File: rtl/corescore_uart_rx.sv
// 8N1 UART receiver with valid/ready output. Define CORESCORE_UART_RX_FIFO_EN
// to buffer FIFO_DEPTH bytes; otherwise a single holding register is used.
module corescore_uart_rx
  import corescore_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD        = 57600,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = bit_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  logic           rx_meta_reg;
  logic           rx_sync_reg;
  logic [1:0]     prime_reg;
  logic           armed_reg;
  uart_rx_state_e state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]     bit_idx_reg, bit_idx_next;
  logic [7:0]     shift_reg, shift_next;
  logic           frame_err_reg, frame_err_next;
  logic           push;

  // prime_reg marks when the synchronizer holds a real line sample rather than
  // its reset value; the receiver arms only after that sample is high.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rx_meta_reg   <= 1'b1;
      rx_sync_reg   <= 1'b1;
      prime_reg     <= 2'b00;
      armed_reg     <= 1'b0;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_meta_reg   <= i_uart_rx;
      rx_sync_reg   <= rx_meta_reg;
      prime_reg     <= {prime_reg[0], 1'b1};
      armed_reg     <= armed_reg | (prime_reg[1] & rx_sync_reg);
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 1'b1;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    frame_err_next = 1'b0;
    push           = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (armed_reg && !rx_sync_reg) begin
          state_next = START;
        end
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rx_sync_reg ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_sync_reg, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_sync_reg) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_next = '0;
        if (rx_sync_reg) begin
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign o_frame_err = frame_err_reg;

`ifdef CORESCORE_UART_RX_FIFO_EN
  corescore_uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_push    (push),
    .i_data    (shift_reg),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_overrun (o_overrun)
  );
`else
  logic [7:0] hold_reg;
  logic       hold_valid_reg;
  logic       overrun_reg;
  logic       pop;

  assign pop = hold_valid_reg && i_ready;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (push && (!hold_valid_reg || pop)) begin
        hold_reg       <= shift_reg;
        hold_valid_reg <= 1'b1;
      end else if (pop) begin
        hold_valid_reg <= 1'b0;
      end
      if (push && hold_valid_reg && !pop) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign o_data    = hold_reg;
  assign o_valid   = hold_valid_reg;
  assign o_overrun = overrun_reg;
`endif

endmodule

// File: tb/tb_corescore_uart_rx.sv
// Randomized scoreboard bench for corescore_uart_rx; stimulus queues expected
// bytes, an independent monitor pops them as the DUT hands them over.
module tb_corescore_uart_rx;

  localparam int CLK_FREQ_HZ = 10_000_000;
  localparam int BAUD        = 57600;
  localparam int CPB         = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int HALF        = CPB / 2;
`ifdef CORESCORE_UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;
  int         ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random
  logic [7:0] exp_q[$];
  logic       ovr_exp = 1'b0;
  int         valid_cycles = 0;
  int         fe_cycles = 0;
  int         last_rise_cyc = 0;

  corescore_uart_rx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_uart_rx  (rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    case (ready_mode)
      0:       i_ready = 1'b0;
      1:       i_ready = 1'b1;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    tests_run = tests_run + 1;
    if (act != exp) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("[TB] ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: sampled 1 time unit after the falling edge, when inputs are settled.
  initial begin
    logic       prev_hold;
    logic       prev_valid;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_hold  = 1'b0;
    prev_valid = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (!rstn) begin
        prev_hold  = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (prev_hold) begin
          if (!o_valid || o_data != prev_data) begin
            check("hold_stable", int'({o_valid, o_data}), int'({1'b1, prev_data}));
          end else begin
            tests_run = tests_run + 1;
          end
        end
        if (o_valid && !prev_valid) last_rise_cyc = cyc;
        if (o_valid) valid_cycles = valid_cycles + 1;
        if (o_frame_err) fe_cycles = fe_cycles + 1;
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", int'(o_data), -1);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", int'(o_data), int'(e));
          end
        end
        prev_hold  = o_valid && !i_ready;
        prev_valid = o_valid;
        prev_data  = o_data;
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  // Reference model: a byte is kept unless the consumer is stalled and the
  // storage (CAP bytes) already holds unread data.
  task automatic send_good(input logic [7:0] b);
    if (ready_mode == 0 && exp_q.size() >= CAP) ovr_exp = 1'b1;
    else exp_q.push_back(b);
    send_frame(b, 1'b1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    repeat (4) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(o_valid), 0);
    check({tag, "_data"}, int'(o_data), 0);
    check({tag, "_frame_err"}, int'(o_frame_err), 0);
    check({tag, "_overrun"}, int'(o_overrun), 0);
  endtask

  initial begin
    #(64'd9_000_000);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int vc0;
    int fe0;
    int t0;
    int gap;
    repeat (5) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);

    // Single byte: valid rises after 2 sync flops + 1 detect cycle + half bit
    // + 9 full bit periods (8 data + stop) measured from the start edge.
    vc0 = valid_cycles;
    t0  = cyc;
    send_good(8'h55);
    wait_drain("t1_drain", 500);
    check("t1_latency", last_rise_cyc, t0 + 3 + HALF + 9 * CPB);
    check("t1_valid_cycles", valid_cycles - vc0, 1);

    // Back-to-back frames with no idle gap.
    vc0 = valid_cycles;
    fe0 = fe_cycles;
    send_good(8'h00);
    send_good(8'hFF);
    send_good(8'hA5);
    wait_drain("t2_drain", 500);
    check("t2_valid_cycles", valid_cycles - vc0, 3);
    check("t2_frame_err", fe_cycles - fe0, 0);

    // Short glitch must be rejected; a following byte proves the receiver idles.
    vc0 = valid_cycles;
    fe0 = fe_cycles;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    check("t3_glitch_valid", valid_cycles - vc0, 0);
    check("t3_glitch_frame_err", fe_cycles - fe0, 0);
    send_good(8'($urandom));
    wait_drain("t3_after_glitch", 500);

    // Low stop bit followed by a long break: one error pulse, no data.
    vc0 = valid_cycles;
    fe0 = fe_cycles;
    send_frame(8'hA5, 1'b0);
    repeat (2000) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    check("t4_frame_err_pulses", fe_cycles - fe0, 1);
    check("t4_valid", valid_cycles - vc0, 0);

    // Stalled consumer: storage fills, extra bytes dropped, overrun sticks.
    ready_mode = 0;
    repeat (3) @(negedge clk);
    for (int b = 1; b <= 5; b++) send_good(8'(b));
    repeat (100) @(negedge clk);
    #1;
    check("t5_overrun", int'(o_overrun), int'(ovr_exp));
    check("t5_head", int'(o_data), int'(exp_q[0]));
    check("t5_depth", exp_q.size(), CAP);
    @(negedge clk);
    ready_mode = 1;
    wait_drain("t5_drain", 500);
    check("t5_overrun_sticky", int'(o_overrun), 1);

    // Reset in the middle of bit 4 of 0x3C abandons the frame.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i >= 2) ? 1'b1 : 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (HALF) @(negedge clk);
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rstn = 1'b1;
    ovr_exp = 1'b0;
    repeat (30) @(negedge clk);
    vc0 = valid_cycles;
    send_good(8'h7E);
    wait_drain("t6_drain", 500);
    check("t6_valid_cycles", valid_cycles - vc0, 1);
    check("t6_overrun", int'(o_overrun), 0);

    // Random bytes, random gaps, random consumer back-pressure.
    fe0 = fe_cycles;
    ready_mode = 2;
    for (int k = 0; k < 8; k++) begin
      gap = int'($urandom_range(0, 200));
      send_good(8'($urandom));
      repeat (gap) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    ready_mode = 1;
    wait_drain("t7_drain", 500);
    check("t7_frame_err", fe_cycles - fe0, 0);
    check("t7_overrun", int'(o_overrun), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/corescore_uart_rx.md
CORESCORE_UART_RX -- requirements
Module: corescore_uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 10_000_000, meaning the i_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 57600, meaning the line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of receive FIFO entries (power of 2, at least 2).
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-005 SHALL have port i_rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port i_uart_rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port o_data, output, 8 bits: head-of-queue received byte.
REQ-008 SHALL have port o_valid, output, 1 bit: o_data holds a byte.
REQ-009 SHALL have port i_ready, input, 1 bit: consumer accepts o_data.
REQ-010 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when a stop bit samples low.
REQ-011 SHALL have port o_overrun, output, 1 bit: sticky flag, set when a byte is dropped because storage is full.

Function
REQ-012 SHALL compute CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD/2) / BAUD, which is 174 for the defaults, and HALF_BIT = CLKS_PER_BIT/2.
REQ-013 SHALL pass i_uart_rx through a 2-flop synchronizer whose flops reset to 1; all decoding uses the synchronized value.
REQ-014 SHALL implement an FSM with states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-015 SHALL leave IDLE for START when it sees the synchronized line low.
REQ-016 In START, SHALL resample the line HALF_BIT cycles after entry: low goes to DATA; high counts as a glitch and returns to IDLE with no output.
REQ-017 In DATA, SHALL sample 8 bits at CLKS_PER_BIT intervals, shifting LSB first, using a 3-bit bit index that wraps 7 to 0 on exit.
REQ-018 In STOP, SHALL sample the line CLKS_PER_BIT cycles after the last data bit.
REQ-019 On a high stop sample, SHALL push the byte and return to IDLE.
REQ-020 On a low stop sample, SHALL discard the byte, pulse o_frame_err for exactly 1 cycle, and enter WAIT_IDLE.
REQ-021 In WAIT_IDLE, SHALL stay until the line samples high, then go to IDLE; a held-low break therefore yields exactly one o_frame_err.
REQ-022 SHALL assert o_valid on the cycle after the push cycle when storage was empty (latency of 1 cycle).
REQ-023 SHALL pop on any cycle with o_valid && i_ready; o_data and o_valid stay stable while o_valid && !i_ready.
REQ-024 On a push and a pop in the same cycle, SHALL perform both and leave the occupancy unchanged, including when storage is full.
REQ-025 On a push into full storage without a simultaneous pop, SHALL drop the new byte, keep existing entries, and set o_overrun.
REQ-026 SHALL clear o_overrun only on reset.
REQ-027 SHALL keep the bit-timing counter at 8 bits or wider, sized from CLKS_PER_BIT, with no wrap during a bit period.

Reset
REQ-028 On i_rstn low, SHALL immediately set FSM=IDLE, synchronizer=1, counters=0, storage empty, o_valid=0, o_data=0, o_frame_err=0 and o_overrun=0.
REQ-029 A reset asserted mid-byte SHALL abandon the frame and produce no partial byte.
REQ-030 After reset release, SHALL treat the line as idle only once it samples high.

Configuration
REQ-031 With macro CORESCORE_UART_RX_FIFO_EN defined, SHALL store bytes in a FIFO_DEPTH-entry circular FIFO with read and write pointers one bit wider than the address to separate full from empty.
REQ-032 Without CORESCORE_UART_RX_FIFO_EN, SHALL use a single holding register: FIFO_DEPTH is ignored, and a push while o_valid && !i_ready is an overrun.

Structure
REQ-033 SHALL place the uart_rx_state_e FSM enum and a clks_per_bit() function in a shared package, corescore_uart_pkg.
REQ-034 SHALL implement storage as one sub-module, corescore_uart_rx_fifo, which is instantiated only when the macro is defined.

Verification
REQ-035 Bench SHALL run defaults at 10 MHz with 174 clocks per bit: send 0x55 with i_ready=1, and expect o_data=0x55 with o_valid high exactly 1 cycle, 1 cycle after the stop sample.
REQ-036 Bench SHALL send 0x00, 0xFF and 0xA5 back-to-back with zero idle time, and expect 3 pulses in order with o_frame_err=0.
REQ-037 Bench SHALL drive a 40-cycle low glitch on an idle line, and expect no o_valid and no o_frame_err, with the FSM back in IDLE.
REQ-038 Bench SHALL send 0xA5 with the stop bit low, then hold the line low for 2000 cycles, and expect exactly 1 o_frame_err pulse and no o_valid.
REQ-039 Bench SHALL send 0x01 to 0x05 with i_ready=0 and the FIFO macro defined, and expect o_overrun=1 and a drain returning 0x01 to 0x04; without the macro, expect the drain to return 0x01 only.
REQ-040 Bench SHALL assert i_rstn low during bit 4 of 0x3C, then release it, send 0x7E, and expect only 0x7E to appear, with o_overrun=0.
